// File: rtl/ascon_word_bridge.sv
// Width-adapting bridge: packs subsystem words into Ascon blocks for the AD/PT FIFOs
// and serialises CT FIFO blocks back into words, first word in the block MSBs.
module ascon_word_bridge #(
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WORD_WIDTH-1:0]  in_data_i,
  input  logic                   in_sel_i,
  input  logic                   in_last_i,
  output logic                   ad_push_o,
  output logic                   pt_push_o,
  output logic [BLOCK_WIDTH-1:0] blk_o,
  input  logic                   ad_full_i,
  input  logic                   pt_full_i,
  output logic                   ct_pop_o,
  input  logic [BLOCK_WIDTH-1:0] ct_i,
  input  logic                   ct_empty_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORD_WIDTH-1:0]  out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam int N = BLOCK_WIDTH / WORD_WIDTH;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic {FILL, PUSH} packState_t;
  typedef enum logic {IDLE, SEND} unpackState_t;

  packState_t             r_packState;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sel;
  logic [BLOCK_WIDTH-1:0] r_blk;

  unpackState_t           r_unpackState;
  logic [CNT_W-1:0]       r_idx;
  logic [BLOCK_WIDTH-1:0] r_ct;

  logic w_clear;
  logic w_inFire;
  logic w_selFull;
  logic w_push;

  assign w_clear    = rst | flush_i;
  assign in_ready_o = (r_packState == FILL) & ~flush_i;
  assign w_inFire   = in_valid_i & in_ready_o;

  // Full flag is used combinationally so a push lands in the cycle the FIFO frees up.
  assign w_selFull  = r_sel ? pt_full_i : ad_full_i;
  assign w_push     = (r_packState == PUSH) & ~w_selFull & ~w_clear;
  assign ad_push_o  = w_push & ~r_sel;
  assign pt_push_o  = w_push & r_sel;
  assign blk_o      = r_blk;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_packState <= FILL;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_blk       <= '0;
    end else begin
      case (r_packState)
        FILL: begin
          if (w_inFire) begin
            if (r_cnt == '0) begin
              r_sel <= in_sel_i;
            end
            r_blk[BLOCK_WIDTH-1 - int'(r_cnt)*WORD_WIDTH -: WORD_WIDTH] <= in_data_i;
            if ((r_cnt == LAST_IDX) || in_last_i) begin
              r_packState <= PUSH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        PUSH: begin
          // Zeroing here is what zero-fills the tail of a short block.
          if (w_push) begin
            r_blk       <= '0;
            r_cnt       <= '0;
            r_packState <= FILL;
          end
        end
        default: r_packState <= FILL;
      endcase
    end
  end

  assign ct_pop_o    = (r_unpackState == IDLE) & ~ct_empty_i & ~w_clear;
  assign out_valid_o = (r_unpackState == SEND);
  assign out_last_o  = (r_unpackState == SEND) & (r_idx == LAST_IDX);
  assign out_data_o  = r_ct[BLOCK_WIDTH-1 - int'(r_idx)*WORD_WIDTH -: WORD_WIDTH];

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_unpackState <= IDLE;
      r_idx         <= '0;
      r_ct          <= '0;
    end else begin
      case (r_unpackState)
        IDLE: begin
          if (ct_pop_o) begin
            r_ct          <= ct_i;
            r_idx         <= '0;
            r_unpackState <= SEND;
          end
        end
        SEND: begin
          if (out_ready_i) begin
            if (r_idx == LAST_IDX) begin
              r_unpackState <= IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_unpackState <= IDLE;
      endcase
    end
  end

  assign busy_o = (r_packState == PUSH) | (r_cnt != '0) | (r_unpackState == SEND);

endmodule

// File: doc/ascon_word_bridge.md
# ascon_word_bridge

Width-adapting stream bridge between the 32-bit subsystem data path and the 64-bit FIFO ports of the Ascon wrapper. On the input side it packs 32-bit words into 64-bit blocks and pushes each block into the AD or PT FIFO. On the output side it pops 64-bit ciphertext blocks from the CT FIFO and serialises them as 32-bit words. It sits directly between the bus-facing register/DMA logic and the Ascon wrapper.

## Interface
- WORD_WIDTH, 32, width of the subsystem-side words.
- BLOCK_WIDTH, 64, Ascon block width; must equal N·WORD_WIDTH with integer N ≥ 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of both paths; drops partial data.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  bridge accepts input word.
- in_data_i  in  WORD_WIDTH  input word.
- in_sel_i  in  1  target of block: 0=AD, 1=PT; sampled on first word of a block only.
- in_last_i  in  1  word is last of its block; remaining words zero-filled.
- ad_push_o  out  1  push strobe to AD FIFO.
- pt_push_o  out  1  push strobe to PT FIFO.
- blk_o  out  BLOCK_WIDTH  packed block; shared data for both FIFOs.
- ad_full_i / pt_full_i  in  1  FIFO full flags.
- ct_pop_o  out  1  pop strobe to CT FIFO.
- ct_i  in  BLOCK_WIDTH  CT FIFO head word (valid when not empty).
- ct_empty_i  in  1  CT FIFO empty.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer accepts output word.
- out_data_o  out  WORD_WIDTH  output word.
- out_last_o  out  1  output word is last word of its block.
- busy_o  out  1  either path holds partial or pending data.

## Operation
- Word order: first word of a block occupies the MSBs (Ascon big-endian). Word k maps to bits [BLOCK_WIDTH-1-k·WORD_WIDTH -: WORD_WIDTH].
- Pack FSM:
  - FILL: in_ready_o=1 unless flush_i. A transfer occurs when in_valid_i & in_ready_o.
    - On the first word (cnt=0), latch in_sel_i into sel.
    - Write the word into slot cnt.
    - If cnt=N-1 or in_last_i, go to PUSH; otherwise cnt++.
  - PUSH: in_ready_o=0.
    - When the selected FIFO's full flag is 0, assert ad_push_o (sel=0) or pt_push_o (sel=1) for exactly one cycle.
    - Then clear the block register, set cnt=0 and return to FILL.
    - While the selected FIFO is full, stay in PUSH and hold blk_o.
  - in_last_i on word 0 yields a block with the word in the MSBs and zeros below it.
  - in_sel_i on non-first words is ignored.
- Unpack FSM:
  - IDLE: when ct_empty_i=0, capture ct_i, assert ct_pop_o in the same cycle, set idx=0 and go to SEND.
  - SEND: out_valid_o=1 and out_data_o=word idx. out_last_o=1 iff idx=N-1.
    - On out_valid_o & out_ready_i: if idx=N-1 go to IDLE, otherwise idx++.
  - ct_pop_o is never asserted outside IDLE and never when ct_empty_i=1.
- The two paths are fully independent and may be active in the same cycle.
- busy_o = (pack state PUSH) | (cnt≠0) | (unpack state SEND).
- flush_i (or rst) in any state:
  - pack path goes to FILL with cnt=0, block register zeroed;
  - unpack path goes to IDLE;
  - no push or pop strobe is asserted in that cycle;
  - any input word presented that cycle is not accepted.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_last_o=0, out_data_o=0, blk_o=0, ad_push_o=0, pt_push_o=0, ct_pop_o=0, busy_o=0. States are FILL and IDLE.
- Pack latency: the push strobe is asserted in the cycle after the final word is accepted, provided the FIFO is not full.
- Pack throughput: N words per N+1 cycles.
- Unpack latency: out_valid_o rises in the cycle after the ct_pop_o cycle. Maximum rate is N words per N+1 cycles.
- Handshakes follow valid/ready rules:
  - out_valid_o and out_data_o stay stable until accepted;
  - in_ready_o does not depend on in_valid_i.
- A full flag that deasserts is honoured combinationally in PUSH; the push occurs in that same cycle.

## Test plan
- Pack to AD: send words 0x01234567 (sel=0) then 0x89ABCDEF → one ad_push_o pulse one cycle later with blk_o=0x0123456789ABCDEF. pt_push_o stays 0.
- Short block to PT: send single word 0xDEADBEEF with sel=1, last=1 → pt_push_o pulse with blk_o=0xDEADBEEF00000000. cnt returns to 0.
- Backpressure: hold pt_full_i=1 and complete a PT block → in_ready_o=0 and blk_o held. Release after 5 cycles → exactly one push in the release cycle, then in_ready_o=1.
- Unpack: CT head 0x0011223344556677, out_ready_i=1 → one ct_pop_o pulse, then words 0x00112233 (last=0) and 0x44556677 (last=1). Inserting out_ready_i=0 stalls with data held stable.
- Flush mid-block: accept 0xCAFEF00D, assert flush_i, then send 0x11111111/0x22222222 (sel=0) → blk_o=0x1111111122222222. The stale word never appears.
- Concurrent paths: run a PT pack and a CT unpack in overlapping cycles → both produce correct output with no cross-interference. After reset mid-SEND, out_valid_o=0 and busy_o=0.
